// File: rtl/riscv_test_pkg.sv
// Shared types, default register indices and helpers for the open_risc_v end-of-test monitor.
package riscv_test_pkg;

  localparam int REG_ADDR_W = 5;

  localparam int DEFAULT_DONE_REG = 26;
  localparam int DEFAULT_PASS_REG = 27;
  localparam int DEFAULT_CODE_REG = 3;

  localparam logic [31:0] DEFAULT_DONE_VALUE = 32'd1;
  localparam logic [31:0] DEFAULT_PASS_VALUE = 32'd1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } mon_state_e;

  // x0 is hard-wired to zero in the core, so a snooped write to it never counts.
  function automatic logic reg_hit(input logic wen, input logic [REG_ADDR_W-1:0] addr,
                                   input int idx);
    return wen && (idx != 0) && (addr == REG_ADDR_W'(idx));
  endfunction

  function automatic logic is_terminal(input mon_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/riscv_test_monitor_shadow.sv
// Shadow copy of one architectural register, loaded from the register-file write-back port.
module reg_snoop_shadow
  import riscv_test_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IDX  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  freeze,
  input  logic                  wen,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]       data,
  output logic [XLEN-1:0]       q
);

  // clr wins over a same-cycle write so a restart discards whatever was in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (!freeze && reg_hit(wen, addr, IDX)) begin
      q <= data;
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: snoops write-back, waits a settle window after the done write, then latches a verdict.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              DONE_REG       = DEFAULT_DONE_REG,
  parameter int              PASS_REG       = DEFAULT_PASS_REG,
  parameter int              CODE_REG       = DEFAULT_CODE_REG,
  parameter logic [XLEN-1:0] DONE_VALUE     = XLEN'(DEFAULT_DONE_VALUE),
  parameter logic [XLEN-1:0] PASS_VALUE     = XLEN'(DEFAULT_PASS_VALUE),
  parameter int              SETTLE_CYCLES  = 50,
  parameter int              TIMEOUT_CYCLES = 100000,
  parameter int              CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic                  rd_wen_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]       rd_data_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [XLEN-1:0]       test_code_o,
  output logic [CNT_W-1:0]      cycle_count_o
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  mon_state_e        state;
  mon_state_e        state_next;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [XLEN-1:0]   pass_shadow;
  logic [XLEN-1:0]   pass_next;
  logic [XLEN-1:0]   unused_done_shadow;
  logic              frozen;
  logic              done_hit;
  logic              timeout_hit;
  logic              counting;

  assign frozen   = is_terminal(state);
  assign counting = (state == ST_RUN) || (state == ST_SETTLE);

  reg_snoop_shadow #(.XLEN(XLEN), .IDX(DONE_REG)) u_done_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (restart),
    .freeze  (frozen),
    .wen     (rd_wen_i),
    .addr    (rd_addr_i),
    .data    (rd_data_i),
    .q       (unused_done_shadow)
  );

  reg_snoop_shadow #(.XLEN(XLEN), .IDX(PASS_REG)) u_pass_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (restart),
    .freeze  (frozen),
    .wen     (rd_wen_i),
    .addr    (rd_addr_i),
    .data    (rd_data_i),
    .q       (pass_shadow)
  );

  reg_snoop_shadow #(.XLEN(XLEN), .IDX(CODE_REG)) u_code_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (restart),
    .freeze  (frozen),
    .wen     (rd_wen_i),
    .addr    (rd_addr_i),
    .data    (rd_data_i),
    .q       (test_code_o)
  );

  // The verdict must see a pass-register write landing on the very edge the window closes.
  assign pass_next   = reg_hit(rd_wen_i, rd_addr_i, PASS_REG) ? rd_data_i : pass_shadow;
  assign done_hit    = reg_hit(rd_wen_i, rd_addr_i, DONE_REG) && (rd_data_i == DONE_VALUE);
  assign cnt_inc     = (&cycle_count_o) ? cycle_count_o : cycle_count_o + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (done_hit) begin
            state_next = ST_SETTLE;
          end else if (timeout_hit) begin
            state_next = ST_TIMEOUT;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_W'(1)) begin
            state_next = (pass_next == PASS_VALUE) ? ST_PASS : ST_FAIL;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Verdict flags follow the next state so they rise on the same edge as the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt    <= '0;
      cycle_count_o <= '0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      timeout_o     <= 1'b0;
    end else if (restart) begin
      settle_cnt    <= '0;
      cycle_count_o <= '0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      if (counting) begin
        cycle_count_o <= cnt_inc;
      end
      if ((state == ST_RUN) && (state_next == ST_SETTLE)) begin
        settle_cnt <= SET_W'(SETTLE_CYCLES);
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end
      done_o    <= is_terminal(state_next);
      pass_o    <= (state_next == ST_PASS);
      fail_o    <= (state_next == ST_FAIL);
      timeout_o <= (state_next == ST_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor with SETTLE_CYCLES=50 and TIMEOUT_CYCLES=200.
module tb_riscv_test_monitor;

  logic        clk;
  logic        reset_n;
  logic        restart;
  logic        rd_wen_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        done_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;
  logic [31:0] test_code_o;
  logic [31:0] cycle_count_o;

  int checks;
  int errors;
  int edge_num;

  riscv_test_monitor #(
    .SETTLE_CYCLES  (50),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .restart       (restart),
    .rd_wen_i      (rd_wen_i),
    .rd_addr_i     (rd_addr_i),
    .rd_data_i     (rd_data_i),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .timeout_o     (timeout_o),
    .test_code_o   (test_code_o),
    .cycle_count_o (cycle_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge; edge_num counts rising edges since reset release.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      edge_num++;
    end
  endtask

  task automatic goto_edge(input int k);
    if (k > edge_num) step(k - edge_num);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    rd_wen_i  = 1'b1;
    rd_addr_i = a;
    rd_data_i = d;
    step(1);
    rd_wen_i  = 1'b0;
    rd_addr_i = '0;
    rd_data_i = '0;
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    restart   = 1'b0;
    rd_wen_i  = 1'b0;
    rd_addr_i = '0;
    rd_data_i = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    edge_num = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done_o); end
    checks++; if (pass_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %0b want 0", pass_o); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail got %0b want 0", fail_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %0b want 0", timeout_o); end
    checks++; if (test_code_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_code got %0d want 0", test_code_o); end
    checks++; if (cycle_count_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", cycle_count_o); end
    goto_edge(5);
    checks++; if (cycle_count_o !== 32'd5) begin errors++; $display("[TB] FAIL run_count got %0d want 5", cycle_count_o); end
  endtask

  task automatic test_pass;
    do_reset();
    goto_edge(4);
    write_reg(5'd27, 32'd1);
    goto_edge(99);
    write_reg(5'd26, 32'd1);
    goto_edge(149);
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_early_done got %0b want 0", done_o); end
    goto_edge(150);
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL pass_done got %0b want 1", done_o); end
    checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL pass_pass got %0b want 1", pass_o); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_fail got %0b want 0", fail_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_timeout got %0b want 0", timeout_o); end
    checks++; if (cycle_count_o !== 32'd150) begin errors++; $display("[TB] FAIL pass_count got %0d want 150", cycle_count_o); end
    goto_edge(155);
    checks++; if (cycle_count_o !== 32'd150) begin errors++; $display("[TB] FAIL pass_count_frozen got %0d want 150", cycle_count_o); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL pass_sticky got %0b want 1", done_o); end
  endtask

  task automatic test_fail_code;
    do_reset();
    write_reg(5'd3, 32'd7);
    write_reg(5'd27, 32'd0);
    write_reg(5'd26, 32'd1);
    goto_edge(52);
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL fail_early_done got %0b want 0", done_o); end
    goto_edge(53);
    checks++; if (fail_o !== 1'b1) begin errors++; $display("[TB] FAIL fail_fail got %0b want 1", fail_o); end
    checks++; if (pass_o !== 1'b0) begin errors++; $display("[TB] FAIL fail_pass got %0b want 0", pass_o); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL fail_done got %0b want 1", done_o); end
    checks++; if (test_code_o !== 32'd7) begin errors++; $display("[TB] FAIL fail_code got %0d want 7", test_code_o); end
    checks++; if (cycle_count_o !== 32'd53) begin errors++; $display("[TB] FAIL fail_count got %0d want 53", cycle_count_o); end
  endtask

  task automatic test_late_write;
    do_reset();
    goto_edge(9);
    write_reg(5'd26, 32'd1);
    goto_edge(58);
    write_reg(5'd27, 32'd1);
    goto_edge(60);
    checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL late_pass got %0b want 1", pass_o); end
    write_reg(5'd27, 32'd0);
    write_reg(5'd3, 32'd9);
    goto_edge(64);
    checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL late_pass_held got %0b want 1", pass_o); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("[TB] FAIL late_fail got %0b want 0", fail_o); end
    checks++; if (test_code_o !== 32'd0) begin errors++; $display("[TB] FAIL late_code_frozen got %0d want 0", test_code_o); end
  endtask

  task automatic test_settle_edges;
    do_reset();
    write_reg(5'd26, 32'd1);
    goto_edge(19);
    write_reg(5'd26, 32'd1);
    goto_edge(50);
    write_reg(5'd27, 32'd1);
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL edge_done got %0b want 1", done_o); end
    checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL edge_pass got %0b want 1", pass_o); end
    checks++; if (cycle_count_o !== 32'd51) begin errors++; $display("[TB] FAIL edge_count got %0d want 51", cycle_count_o); end
  endtask

  task automatic test_timeout;
    do_reset();
    goto_edge(199);
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL to_early got %0b want 0", timeout_o); end
    goto_edge(200);
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL to_timeout got %0b want 1", timeout_o); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL to_done got %0b want 1", done_o); end
    checks++; if ({pass_o, fail_o} !== 2'b00) begin errors++; $display("[TB] FAIL to_onehot got %b want 00", {pass_o, fail_o}); end
    checks++; if (cycle_count_o !== 32'd200) begin errors++; $display("[TB] FAIL to_count got %0d want 200", cycle_count_o); end
    do_reset();
    goto_edge(199);
    write_reg(5'd26, 32'd1);
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL to_done_wins got %0b want 0", timeout_o); end
    goto_edge(250);
    checks++; if (fail_o !== 1'b1) begin errors++; $display("[TB] FAIL to_settle_fail got %0b want 1", fail_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL to_settle_timeout got %0b want 0", timeout_o); end
    checks++; if (cycle_count_o !== 32'd250) begin errors++; $display("[TB] FAIL to_settle_count got %0d want 250", cycle_count_o); end
  endtask

  task automatic test_ignored;
    do_reset();
    write_reg(5'd0, 32'd1);
    write_reg(5'd26, 32'd5);
    goto_edge(60);
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL ign_done got %0b want 0", done_o); end
    checks++; if (cycle_count_o !== 32'd60) begin errors++; $display("[TB] FAIL ign_count got %0d want 60", cycle_count_o); end
  endtask

  task automatic test_restart;
    do_reset();
    write_reg(5'd27, 32'd1);
    write_reg(5'd26, 32'd1);
    goto_edge(52);
    checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL rs_pass_before got %0b want 1", pass_o); end
    goto_edge(54);
    restart = 1'b1;
    write_reg(5'd3, 32'd4);
    restart = 1'b0;
    checks++; if ({done_o, pass_o, fail_o, timeout_o} !== 4'b0000) begin errors++; $display("[TB] FAIL rs_flags got %b want 0000", {done_o, pass_o, fail_o, timeout_o}); end
    checks++; if (cycle_count_o !== 32'd0) begin errors++; $display("[TB] FAIL rs_count got %0d want 0", cycle_count_o); end
    goto_edge(60);
    checks++; if (cycle_count_o !== 32'd5) begin errors++; $display("[TB] FAIL rs_count_run got %0d want 5", cycle_count_o); end
    write_reg(5'd26, 32'd1);
    goto_edge(111);
    checks++; if (fail_o !== 1'b1) begin errors++; $display("[TB] FAIL rs_fail got %0b want 1", fail_o); end
    checks++; if (test_code_o !== 32'd0) begin errors++; $display("[TB] FAIL rs_code got %0d want 0", test_code_o); end
    checks++; if (cycle_count_o !== 32'd56) begin errors++; $display("[TB] FAIL rs_count_final got %0d want 56", cycle_count_o); end
  endtask

  task automatic test_async_reset;
    do_reset();
    write_reg(5'd27, 32'd1);
    write_reg(5'd26, 32'd1);
    goto_edge(20);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cycle_count_o !== 32'd0) begin errors++; $display("[TB] FAIL ar_count got %0d want 0", cycle_count_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL ar_done got %0b want 0", done_o); end
    @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    edge_num = 0;
    goto_edge(60);
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL ar_no_verdict got %0b want 0", done_o); end
    checks++; if (cycle_count_o !== 32'd60) begin errors++; $display("[TB] FAIL ar_count_run got %0d want 60", cycle_count_o); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    edge_num = 0;
    test_reset();
    test_pass();
    test_fail_code();
    test_late_write();
    test_settle_edges();
    test_timeout();
    test_ignored();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable, parametrised end-of-test monitor for the open_risc_v core. It snoops the register-file write-back port and keeps shadow copies of the done, pass and test-code registers (x26, x27 and x3 by default). It delivers a registered pass/fail/timeout verdict with the failing test number and a cycle count. It replaces the fixed-delay, simulation-only check and can sit inside open_risc_v_soc beside regs_inst, with outputs wired to LEDs or a debug bus.

## Interface
- XLEN, 32: register data width.
- DONE_REG, 26: register index whose write of DONE_VALUE ends the test.
- PASS_REG, 27: register index sampled for the verdict.
- CODE_REG, 3: register index reported as the test number (gp).
- DONE_VALUE, 1: value on DONE_REG that triggers settle.
- PASS_VALUE, 1: PASS_REG value meaning pass.
- SETTLE_CYCLES, 50: cycles between the done write and the verdict; legal range ≥1.
- TIMEOUT_CYCLES, 100000: RUN-state cycle limit; 0 disables the timeout.
- CNT_W, 32: cycle counter width.

- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous clear back to RUN; takes priority over every other event.
- rd_wen_i  in  1  register-file write enable.
- rd_addr_i  in  5  write index.
- rd_data_i  in  XLEN  write data.
- done_o  out  1  verdict valid; sticky.
- pass_o  out  1  test passed; sticky.
- fail_o  out  1  test failed; sticky.
- timeout_o  out  1  no done write within TIMEOUT_CYCLES; sticky.
- test_code_o  out  XLEN  CODE_REG shadow, frozen at the verdict.
- cycle_count_o  out  CNT_W  cycles spent in RUN+SETTLE, frozen at the verdict.

## Operation
- States:
  - RUN.
  - SETTLE.
  - PASS, FAIL and TIMEOUT (terminal).
- Reset and restart both enter RUN and zero all shadows, counters and outputs.
- Shadows:
  - On rd_wen_i with rd_addr_i==index, the matching shadow loads rd_data_i.
  - Writes to index 0 are ignored.
  - Shadows update in RUN and SETTLE, and freeze in terminal states.
- Transitions:
  - RUN→SETTLE on a write of DONE_VALUE to DONE_REG. The settle counter loads SETTLE_CYCLES.
  - A done-register write of any other value only updates the shadow.
  - SETTLE decrements the counter once per cycle. On the edge where the counter is 1, the state moves to PASS if the next-state PASS_REG shadow equals PASS_VALUE, otherwise to FAIL. The next-state shadow includes a write sampled on that same edge.
  - Further done writes during SETTLE do not reload the counter.
  - RUN→TIMEOUT when TIMEOUT_CYCLES≠0 and cycle_count_o equals TIMEOUT_CYCLES.
  - If a done write and the timeout condition land on the same edge, the done write wins.
  - SETTLE never times out.
- Outputs in terminal states:
  - done_o=1 in all terminal states.
  - pass_o, fail_o and timeout_o are one-hot, matching the terminal state.
- cycle_count_o saturates at all-ones.

## Timing
- Every output is registered. All outputs reset to 0.
- Write sampled at edge E0 → done_o rises after edge E0+SETTLE_CYCLES.
- test_code_o and cycle_count_o are valid on the same cycle that done_o rises.
- A restart asserted on edge E clears the outputs after E. Monitoring resumes at E+1, and any write sampled at E is discarded.
- Reset asserted mid-SETTLE aborts immediately and asynchronously; no verdict is produced.

## Structure
- Package riscv_test_pkg holds:
  - The state enum.
  - Default register indices 26, 27 and 3.
  - The default DONE_VALUE and PASS_VALUE.
- Sub-module reg_snoop_shadow (parameters XLEN and IDX; ports clk, reset_n, clr, freeze, wen, addr, data, q) is instantiated three times.
- The FSM, settle counter and cycle counter live in the top module.

## Test plan
- Pass: write x27=1, then x26=1 at edge 100, with SETTLE_CYCLES=50 → done_o and pass_o rise after edge 150; cycle_count_o=150.
- Fail with code: write x3=7, x27=0, then x26=1 → fail_o=1, test_code_o=7, pass_o=0.
- Late write inside the window: x26=1 at edge 10, then x27=1 at edge 59 (SETTLE_CYCLES=50) → pass_o=1. A write at edge 61 must not change the verdict.
- Timeout: TIMEOUT_CYCLES=200 with no done write → timeout_o rises after edge 200. A done write on edge 200 instead gives SETTLE, not timeout.
- Ignored writes: a write to x0, and a write of 5 to x26 → remain in RUN with no verdict.
- Restart/reset: pulse restart in the PASS state → all outputs 0 and the counters restart. Drop reset_n mid-SETTLE → outputs clear asynchronously and no verdict follows.
